lincomb_seq: RTL and testbench
==============================

// Module: lincomb_seq
// PURPOSE
//  Multi-cycle, parametrised linear-combination unit: O = KA*A - KB*B.
//  Successor to the fixed 16-bit 3A-2B datapath, with a start/done handshake,
//  runtime coefficients, and signed or unsigned mode.
//  Products are built by serial shift-add, one coefficient bit per cycle.
//  Overflow, borrow and validity flags follow the adder/subtractor semantics.
// PARAMETERS
//  WIDTH  16  operand and result width in bits (>= 4)
//  CW     4   coefficient width in bits (>= 1); KA and KB are always unsigned
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request; sampled only in IDLE
//  S           in   1      1 = A,B two's-complement signed; 0 = unsigned
//  A           in   WIDTH  operand A
//  B           in   WIDTH  operand B
//  KA          in   CW     coefficient applied to A
//  KB          in   CW     coefficient applied to B
//  busy        out  1      high from the cycle after start is accepted until done
//  done        out  1      one-cycle pulse when O and flags update
//  O           out  WIDTH  result, truncated to WIDTH bits, held until next done
//  overflag    out  1      S=1: exact result outside signed WIDTH range;
//                          S=0: result > 2^WIDTH-1
//  borrowflag  out  1      S=0 and KA*A < KB*B; always 0 when S=1
//  validity    out  1      ~(overflag | borrowflag); registered with O
// BEHAVIOUR
//  - Reset (async, any state): FSM -> IDLE; busy=0, done=0, O=0, overflag=0,
//    borrowflag=0, validity=0. An in-flight operation is discarded; no done pulse.
//  - FSM: IDLE -> MULA (CW cycles) -> MULB (CW cycles) -> SUB (1) -> FIN (1) -> IDLE.
//  - IDLE: on an edge with start=1, register A, B, KA, KB and S, clear the
//    accumulators, and go to MULA. Inputs are not sampled again until the next IDLE.
//  - start while busy is ignored. It is not queued.
//  - MULA: iterate KA LSB first. If the bit is 1, PA += A<<i.
//    PA is WIDTH+CW bits, with A sign-extended when S=1.
//  - MULB: the same iteration for KB into PB.
//  - SUB: D = PA - PB, computed at WIDTH+CW+1 bits (signed when S=1).
//  - FIN: drive O = D[WIDTH-1:0], set the flags from the full-width D, and pulse done.
//  - Flag rules:
//      S=0: borrowflag = D<0; overflag = D>2^WIDTH-1.
//      S=1: overflag = D<-2^(WIDTH-1) or D>2^(WIDTH-1)-1.
//  - Latency: the start edge is edge 0. done is high during the cycle after
//    edge 2*CW+2 (10 for CW=4), and busy falls on that same edge.
//  - A new start may be accepted in the cycle done is high. That edge is edge 0
//    of the next operation.
//  - Coefficient 0 leaves its product at 0, but the cycle count stays fixed.
//  - O and the flags change only in FIN or on reset.
// TESTING (WIDTH=16, CW=4)
//  1. S=1, A=100, KA=3, B=50, KB=2, start pulse -> done 10 cycles later;
//     O=16'd200, validity=1, flags=0.
//  2. S=1, A=16'hFFFB (-5), KA=3, B=4, KB=2 -> O=16'hFFE9 (-23), validity=1.
//  3. S=1, A=16'h4000, KA=3, KB=0 -> O=16'hC000, overflag=1, validity=0.
//  4. S=0, A=10, KA=1, B=20, KB=1 -> O=16'hFFF6, borrowflag=1, overflag=0,
//     validity=0.
//     S=0, A=16'hFFFF, KA=2, KB=0 -> O=16'hFFFE, overflag=1.
//  5. Pulse start again at cycle 3 of case 1 -> ignored; exactly one done.
//     Then assert rst at cycle 5 -> busy=0, O=0, no done.
//     Then a new start completes normally.
//  6. Back-to-back: re-assert start in the done cycle with KA=KB=0
//     -> second done 10 cycles later; O=0, validity=1.

Source files
------------

// File: rtl/lincomb_seq_if.sv
// Bus bundle for lincomb_seq: request/operand signals from the requester
// and result/status signals from the unit.
//   start       request pulse, sampled only while the unit is idle
//   S           1 = operands are two's complement, 0 = unsigned
//   A, B        WIDTH-bit operands
//   KA, KB      CW-bit unsigned coefficients
//   busy        high while an operation is in flight
//   done        one-cycle pulse when O and the flags update
//   O           truncated result KA*A - KB*B
//   overflag    result outside the representable range for the mode
//   borrowflag  unsigned mode only: KA*A < KB*B
//   validity    ~(overflag | borrowflag)
interface lincomb_seq_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 4
);
  logic             start;
  logic             S;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [CW-1:0]    KA;
  logic [CW-1:0]    KB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] O;
  logic             overflag;
  logic             borrowflag;
  logic             validity;

  modport master (
    output start, S, A, B, KA, KB,
    input  busy, done, O, overflag, borrowflag, validity
  );

  modport slave (
    input  start, S, A, B, KA, KB,
    output busy, done, O, overflag, borrowflag, validity
  );
endinterface

// File: rtl/lincomb_seq.sv
// Multi-cycle linear-combination unit: O = KA*A - KB*B.
// Each product is built by serial shift-add, one coefficient bit per cycle,
// so an operation always takes 2*CW+3 cycles from the start edge to the
// cycle in which done is high, regardless of the coefficient values.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; aborts any operation
//   bus   lincomb_seq_if slave modport (start/S/A/B/KA/KB in,
//         busy/done/O/overflag/borrowflag/validity out)
module lincomb_seq #(
  parameter int WIDTH = 16,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          rst,
  lincomb_seq_if.slave bus
);

  localparam int PW    = WIDTH + CW;                      // product width
  localparam int DW    = PW + 1;                          // difference width
  localparam int CNT_W = (CW > 1) ? $clog2(CW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CW - 1);

  typedef enum logic [2:0] {IDLE, MULA, MULB, SUB, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, step_a, step_b, do_sub, fin;

  logic signed [PW-1:0] a_sh_q, b_sh_q;
  logic signed [PW-1:0] pa_q, pb_q;
  logic signed [DW-1:0] d_q;
  logic [CW-1:0]        ka_q, kb_q;
  logic                 s_q;

  logic [WIDTH-1:0] o_q;
  logic             over_q, borrow_q, valid_q, done_q;

  // Signed mode: any bit above the signed WIDTH range differing from the
  // sign bit means the exact result does not fit. Unsigned mode: a
  // non-negative difference with any bit set at or above WIDTH.
  function automatic logic over_f(input logic signed [DW-1:0] d, input logic sgn);
    logic [DW-WIDTH:0] top;
    top = d[DW-1:WIDTH-1];
    if (sgn) over_f = !((&top) || (~|top));
    else     over_f = !d[DW-1] && (|d[DW-2:WIDTH]);
  endfunction

  function automatic logic borrow_f(input logic signed [DW-1:0] d, input logic sgn);
    borrow_f = !sgn && d[DW-1];
  endfunction

  function automatic logic signed [PW-1:0] ext_op(input logic [WIDTH-1:0] x, input logic sgn);
    ext_op = {{CW{sgn & x[WIDTH-1]}}, x};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step_a  = 1'b0;
    step_b  = 1'b0;
    do_sub  = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = MULA;
        end
      end
      MULA: begin
        step_a = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = MULB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MULB: begin
        step_b = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = SUB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SUB: begin
        do_sub  = 1'b1;
        state_d = FIN;
      end
      FIN: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and shift-add: the shifted operand and the coefficient
  // shift in lockstep, so bit 0 of the coefficient always selects the
  // operand already weighted by 2^i.
  always_ff @(posedge clk) begin
    if (load) begin
      a_sh_q <= ext_op(bus.A, bus.S);
      b_sh_q <= ext_op(bus.B, bus.S);
      ka_q   <= bus.KA;
      kb_q   <= bus.KB;
      s_q    <= bus.S;
      pa_q   <= '0;
      pb_q   <= '0;
    end
    if (step_a) begin
      if (ka_q[0]) pa_q <= pa_q + a_sh_q;
      a_sh_q <= a_sh_q <<< 1;
      ka_q   <= ka_q >> 1;
    end
    if (step_b) begin
      if (kb_q[0]) pb_q <= pb_q + b_sh_q;
      b_sh_q <= b_sh_q <<< 1;
      kb_q   <= kb_q >> 1;
    end
    // One extra bit so the unsigned borrow shows up as a sign bit.
    if (do_sub) begin
      d_q <= {s_q & pa_q[PW-1], pa_q} - {s_q & pb_q[PW-1], pb_q};
    end
  end

  // Result stage: O and flags update only on the FIN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q      <= '0;
      over_q   <= 1'b0;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        o_q      <= d_q[WIDTH-1:0];
        over_q   <= over_f(d_q, s_q);
        borrow_q <= borrow_f(d_q, s_q);
        valid_q  <= !(over_f(d_q, s_q) || borrow_f(d_q, s_q));
      end
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.O          = o_q;
  assign bus.overflag   = over_q;
  assign bus.borrowflag = borrow_q;
  assign bus.validity   = valid_q;

endmodule

// File: tb/tb_lincomb_seq.sv
module tb_lincomb_seq;

  localparam int W  = 16;
  localparam int CW = 4;
  localparam int LAT = 2 * CW + 3;

  typedef struct {
    logic [W-1:0] o;
    logic         ov;
    logic         br;
    logic         va;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q[$];

  lincomb_seq_if #(.WIDTH(W), .CW(CW)) bus ();

  lincomb_seq #(.WIDTH(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Monitor: pops and compares every time the DUT pulses done.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d required no pending op", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("O",          32'(bus.O),          32'(e.o));
        chk("overflag",   32'(bus.overflag),   32'(e.ov));
        chk("borrowflag", 32'(bus.borrowflag), 32'(e.br));
        chk("validity",   32'(bus.validity),   32'(e.va));
        chk("latency",    32'(cyc),            32'(e.cyc));
      end
    end
  end

  // Called at a negedge; drives start for one cycle, returns at the
  // negedge after the start edge.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [CW-1:0] ka,
                       input logic [W-1:0] b, input logic [CW-1:0] kb,
                       input logic [W-1:0] eo, input logic eov, input logic ebr,
                       input logic eva, input bit push);
    exp_t e;
    bus.S = s; bus.A = a; bus.KA = ka; bus.B = b; bus.KB = kb;
    bus.start = 1'b1;
    if (push) begin
      e.o = eo; e.ov = eov; e.br = ebr; e.va = eva; e.cyc = cyc + LAT;
      q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending ops required 0", q.size());
      q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.S = 1'b0; bus.A = '0; bus.B = '0; bus.KA = '0; bus.KB = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   32'(bus.busy),       32'd0);
    chk("rst_done",   32'(bus.done),       32'd0);
    chk("rst_O",      32'(bus.O),          32'd0);
    chk("rst_over",   32'(bus.overflag),   32'd0);
    chk("rst_borrow", 32'(bus.borrowflag), 32'd0);
    chk("rst_valid",  32'(bus.validity),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors: s, A, KA, B, KB -> O, over, borrow, valid
    issue(1, 16'd100,  4'd3,  16'd50,  4'd2, 16'h00C8, 0, 0, 1, 1); drain();
    issue(1, 16'hFFFB, 4'd3,  16'd4,   4'd2, 16'hFFE9, 0, 0, 1, 1); drain();
    issue(1, 16'h4000, 4'd3,  16'd7,   4'd0, 16'hC000, 1, 0, 0, 1); drain();
    issue(0, 16'd10,   4'd1,  16'd20,  4'd1, 16'hFFF6, 0, 1, 0, 1); drain();
    issue(0, 16'hFFFF, 4'd2,  16'd9,   4'd0, 16'hFFFE, 1, 0, 0, 1); drain();
    issue(1, 16'h8000, 4'd1,  16'd1,   4'd1, 16'h7FFF, 1, 0, 0, 1); drain();
    issue(0, 16'hFFFF, 4'd1,  16'd5,   4'd0, 16'hFFFF, 0, 0, 1, 1); drain();
    issue(0, 16'h1000, 4'd15, 16'h1000, 4'd14, 16'h1000, 0, 0, 1, 1); drain();

    // start while busy is ignored: one done only, result from first operands
    issue(1, 16'd100, 4'd3, 16'd50, 4'd2, 16'h00C8, 0, 0, 1, 1);
    @(negedge clk);
    bus.A = 16'd1; bus.KA = 4'd1; bus.B = 16'd0; bus.KB = 4'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_mid", 32'(bus.busy), 32'd1);
    drain();
    repeat (12) @(negedge clk);

    // Reset mid-operation: discarded, no done
    issue(1, 16'd7, 4'd1, 16'd0, 4'd0, 16'h0000, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy",  32'(bus.busy),     32'd0);
    chk("abort_O",     32'(bus.O),        32'd0);
    chk("abort_done",  32'(bus.done),     32'd0);
    chk("abort_valid", 32'(bus.validity), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    issue(1, 16'hFFFB, 4'd3, 16'd4, 4'd2, 16'hFFE9, 0, 0, 1, 1); drain();

    // Back-to-back: new start in the done cycle
    issue(1, 16'd100, 4'd3, 16'd50, 4'd2, 16'h00C8, 0, 0, 1, 1);
    begin
      int n = 0;
      while (bus.done !== 1'b1 && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (bus.done !== 1'b1) begin
        n_total++;
        $display("FAIL b2b_wait: got no done required done within 30 cycles");
      end
    end
    issue(1, 16'd1234, 4'd0, 16'd321, 4'd0, 16'h0000, 0, 0, 1, 1);
    #1;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
